// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM state type and parity-mode constants for serial_parity_checker
package parity_pkg;

  typedef enum logic [1:0] {
    DATA,
    PARITY,
    HOLD
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Value XORed into the received parity so that a correct frame yields 0.
  function automatic logic parity_seed(input int mode);
    return (mode == PAR_ODD) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/parity_err_counter.sv
// rtl/parity_err_counter.sv - saturating event counter with enable and synchronous clear
module parity_err_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - LSB-first serial frame receiver with parity check
// Defining PARITY_ERR_CNT_EN adds the err_count port and its saturating counter.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ODD       = 0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  input  logic                 frame_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_err
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     err_count
`endif
);

  localparam int            CW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST   = CW'(FRAME_LEN - 1);
  localparam logic          ODD_B  = parity_seed(ODD);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic                   err_q, err_d;
  logic [FRAME_LEN-1:0]   data_q;
  logic                   shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DATA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    err_d     = err_q;
    shift_en  = 1'b0;
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    case (state_q)
      DATA: begin
        if (frame_clr) begin
          cnt_d = '0;
          acc_d = 1'b0;
        end else if (in_valid) begin
          shift_en = 1'b1;
          acc_d    = acc_q ^ in_bit;
          // Counter parks on the last index; it is cleared when the frame is delivered.
          if (cnt_q == LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (frame_clr) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end else if (in_valid) begin
          err_d   = acc_q ^ in_bit ^ ODD_B;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      default: begin
        state_d = DATA;
        cnt_d   = '0;
        acc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      err_q <= err_d;
      if (shift_en) begin
        data_q[cnt_q] <= in_bit;
      end
    end
  end

  assign out_data = data_q;
  assign out_err  = err_q;

`ifdef PARITY_ERR_CNT_EN
  parity_err_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (out_valid && out_ready && err_q),
    .clr  (1'b0),
    .count(err_count)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - randomized self-checking bench for serial_parity_checker
module tb_serial_parity_checker;

  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_ready;
  logic          frame_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FL-1:0] out_data;
  logic          out_err;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  int tests = 0;
  int fails = 0;

  serial_parity_checker #(.FRAME_LEN(FL), .ODD(0), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .frame_clr(frame_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a list of received bits, a ones count, and a held frame.
  int          m_nbits;
  int          m_ones;
  logic [FL-1:0] m_word;
  bit          m_hold;
  logic [FL-1:0] m_data;
  bit          m_err;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nbits = 0; m_ones = 0; m_word = '0; m_hold = 0;
      m_data = '0; m_err = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
        m_hold = 0; m_nbits = 0; m_ones = 0;
      end
    end else if (frame_clr) begin
      m_nbits = 0; m_ones = 0;
    end else if (in_valid) begin
      if (m_nbits < FL) begin
        m_word[m_nbits] = in_bit;
        m_ones = m_ones + int'(in_bit);
        m_nbits = m_nbits + 1;
      end else begin
        m_data = m_word;
        m_err  = ((m_ones + int'(in_bit)) % 2) != 0;
        m_hold = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
      if (m_hold) begin
        check("out_data", {24'd0, out_data}, {24'd0, m_data});
        check("out_err", {31'd0, out_err}, {31'd0, m_err});
      end
`ifdef PARITY_ERR_CNT_EN
      check("err_count", {24'd0, err_count}, m_cnt);
`endif
    end
  end

  task automatic step(input logic v, input logic b, input logic clr, input logic ordy);
    in_valid = v; in_bit = b; frame_clr = clr; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [FL-1:0] w, input logic par, input logic ordy);
    for (int i = 0; i < FL; i++) step(1'b1, w[i], 1'b0, ordy);
    step(1'b1, par, 1'b0, ordy);
  endtask

  initial begin
    logic [FL-1:0] w;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 0xA5 with correct even parity: valid the cycle after the parity bit.
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_valid", {31'd0, out_valid}, 32'd1);
    check("a5_data", {24'd0, out_data}, 32'h A5);
    check("a5_err", {31'd0, out_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Same word, wrong parity.
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5e_data", {24'd0, out_data}, 32'h A5);
    check("a5e_err", {31'd0, out_err}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    check("a5e_cnt", {24'd0, err_count}, 32'd1);
`endif

    // Backpressure: bits offered during HOLD must not be consumed.
    send_frame(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_data", {24'd0, out_data}, 32'h 5A);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, 1'b1);
    check("bp_next_data", {24'd0, out_data}, 32'h 96);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort with a simultaneous bit, then a clean 0xFF.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("clr_data", {24'd0, out_data}, 32'h FF);
    check("clr_err", {31'd0, out_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", {24'd0, out_data}, 32'd0);
    check("arst_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1);
    check("arst_next_data", {24'd0, out_data}, 32'h 3C);
    check("arst_next_err", {31'd0, out_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic with gaps, aborts and backpressure.
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 20) == 0, ($urandom % 3) != 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // 260 errored frames to drive the counter into saturation.
    for (int f = 0; f < 260; f++) begin
      w = FL'($urandom);
      send_frame(w, ~(^w), 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("sat_last_err", {31'd0, out_err}, 32'd1);
`ifdef PARITY_ERR_CNT_EN
    check("sat_cnt", {24'd0, err_count}, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
